direction_sequencer: RTL

DIRECTION_SEQUENCER -- requirements
Module: direction_sequencer

---
 rtl/direction_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/direction_sequencer.sv
// direction_sequencer: game-state FSM with a buffered turn queue for a grid-movement game.
// Define DIR_QUEUE_EN for a 2-entry turn FIFO; without it a single overwrite slot is used.
module direction_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] direction_in,
  input  logic       direction_valid_in,
  input  logic       start_pause_event_in,
  input  logic       reset_event_in,
  input  logic       tick_in,
  input  logic       game_over_in,
  output logic [1:0] cur_dir_out,
  output logic       step_out,
  output logic [1:0] state_out,
  output logic       game_reset_out,
  output logic [1:0] q_count_out,
  output logic       drop_out
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_OVER  = 2'b11;

  localparam logic [1:0] DIR_RIGHT = 2'b11;

  logic [1:0] state_q, state_d;
  logic [1:0] cur_q, cur_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] q0_q, q0_d;
`ifdef DIR_QUEUE_EN
  logic [1:0] q1_q, q1_d;
  logic [1:0] post_q0;
`endif
  logic       step_q, drop_q, grst_q;
  logic       step_d, drop_d, grst_d;

  logic       run_active;
  logic       flush;
  logic       pop_en;
  logic [1:0] post_cur;
  logic [1:0] post_cnt;
  logic [1:0] ref_dir;
  logic       full_block;
  logic       push_reject;
  logic       push_ok;

  // Movement and queue activity only when running and no higher-priority event.
  assign run_active = (state_q == S_RUN) && !reset_event_in && !game_over_in;
  assign flush      = reset_event_in || ((state_q == S_OVER) && start_pause_event_in);

  // A same-cycle tick pops first; the push is judged against the post-pop view.
  assign pop_en   = run_active && tick_in && (cnt_q != 2'd0);
  assign post_cur = pop_en ? q0_q : cur_q;
  assign post_cnt = pop_en ? (cnt_q - 2'd1) : cnt_q;

`ifdef DIR_QUEUE_EN
  assign post_q0    = pop_en ? q1_q : q0_q;
  assign full_block = (post_cnt == 2'd2);

  always_comb begin
    ref_dir = post_cur;
    if (post_cnt == 2'd1) begin
      ref_dir = post_q0;
    end else if (post_cnt == 2'd2) begin
      ref_dir = q1_q;
    end
  end
`else
  assign full_block = 1'b0;
  assign ref_dir    = post_cur;
`endif

  // Codes differing only in bit 0 are opposites (up/down, left/right).
  assign push_reject = (direction_in == ref_dir) ||
                       ((direction_in ^ ref_dir) == 2'b01) ||
                       full_block;
  assign push_ok     = run_active && direction_valid_in && !push_reject;

  assign step_d = run_active && tick_in;
  assign drop_d = run_active && direction_valid_in && push_reject;
  assign grst_d = flush;

  always_comb begin
    state_d = state_q;
    if (reset_event_in) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start_pause_event_in) state_d = S_RUN;
        S_RUN: begin
          if (game_over_in) begin
            state_d = S_OVER;
          end else if (start_pause_event_in) begin
            state_d = S_PAUSE;
          end
        end
        S_PAUSE: if (start_pause_event_in) state_d = S_RUN;
        S_OVER:  if (start_pause_event_in) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cur_d = post_cur;
    cnt_d = post_cnt;
`ifdef DIR_QUEUE_EN
    q0_d  = post_q0;
    q1_d  = q1_q;
    if (push_ok) begin
      if (post_cnt == 2'd0) begin
        q0_d = direction_in;
      end else begin
        q1_d = direction_in;
      end
      cnt_d = post_cnt + 2'd1;
    end
`else
    q0_d  = q0_q;
    if (push_ok) begin
      q0_d  = direction_in;
      cnt_d = 2'd1;
    end
`endif
    if (flush) begin
      cnt_d = '0;
      cur_d = DIR_RIGHT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cur_q   <= DIR_RIGHT;
      cnt_q   <= '0;
      q0_q    <= '0;
`ifdef DIR_QUEUE_EN
      q1_q    <= '0;
`endif
      step_q  <= 1'b0;
      drop_q  <= 1'b0;
      grst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      q0_q    <= q0_d;
`ifdef DIR_QUEUE_EN
      q1_q    <= q1_d;
`endif
      step_q  <= step_d;
      drop_q  <= drop_d;
      grst_q  <= grst_d;
    end
  end

  assign cur_dir_out    = cur_q;
  assign step_out       = step_q;
  assign state_out      = state_q;
  assign game_reset_out = grst_q;
  assign q_count_out    = cnt_q;
  assign drop_out       = drop_q;

endmodule
